alpha_bringup_sequencer: RTL and testbench

Parametrised bring-up sequencer for ALPHA evaluation boards. It replaces the hand-written chain of per-step counters, `has_occurred` flags and button gating with one state machine. The machine walks NUM_STEPS ordered steps, such as dreset, legacy serial, I2C and trigger. Each step starts either after a power-of-two delay or on a manual trigger pulse. The sequencer then waits for the step's engine to go idle, with a timeout. It sits between the board-level reset/button logic and `alpha_control`'s `initiate_*` inputs.

---
 rtl/alpha_pkg.sv | 18 +
 rtl/alpha_bringup_sequencer_pickoff_counter.sv | 31 +++
 rtl/alpha_bringup_sequencer.sv | 159 +++++++++++++++
 tb/tb_alpha_bringup_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_pkg.sv
// Shared constants for the ALPHA board bring-up logic:
// sequencer state encoding, default pickoff bits, step-index width helper.
package alpha_pkg;

   localparam logic [2:0] ST_WAIT = 3'd0;
   localparam logic [2:0] ST_FIRE = 3'd1;
   localparam logic [2:0] ST_BUSY = 3'd2;
   localparam logic [2:0] ST_NEXT = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam int DEFAULT_DELAY_PICKOFF   = 26;
   localparam int DEFAULT_TIMEOUT_PICKOFF = 20;

   function automatic int step_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alpha_bringup_sequencer_pickoff_counter.sv
// Saturating up-counter that flags once bit PICKOFF is set and then holds.
// Ports: clock, clear (sync, wins), enable (count), expired (bit PICKOFF).
module pickoff_counter #(
   parameter int PICKOFF = 4
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [PICKOFF:0] cnt_q;
   logic [PICKOFF:0] cnt_d;

   assign expired = cnt_q[PICKOFF];

   // Stops at the pickoff so a long wait can never wrap back to "not expired".
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !cnt_q[PICKOFF]) begin
         cnt_d = cnt_q + (PICKOFF + 1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/alpha_bringup_sequencer.sv
// Bring-up sequencer: walks NUM_STEPS ordered steps, each started after a
// power-of-two delay or a manual trigger, then waits for the engine to go
// idle (with timeout). Ports: clock100/reset (sync, active-high), restart,
// step_enable/manual_mask/step_busy per step, trigger_pulse, repeat_mode;
// outputs initiate (one-hot pulse), has_occurred/timed_out (sticky),
// current_step, done. All outputs are registered.
module alpha_bringup_sequencer
   import alpha_pkg::*;
#(
   parameter int NUM_STEPS       = 4,
   parameter int DELAY_PICKOFF   = DEFAULT_DELAY_PICKOFF,
   parameter int TIMEOUT_PICKOFF = DEFAULT_TIMEOUT_PICKOFF,
   parameter int STEP_W          = step_width(NUM_STEPS)
) (
   input  logic                 clock100,
   input  logic                 reset,
   input  logic [NUM_STEPS-1:0] step_enable,
   input  logic [NUM_STEPS-1:0] manual_mask,
   input  logic                 trigger_pulse,
   input  logic                 restart,
   input  logic                 repeat_mode,
   input  logic [NUM_STEPS-1:0] step_busy,
   output logic [NUM_STEPS-1:0] initiate,
   output logic [NUM_STEPS-1:0] has_occurred,
   output logic [NUM_STEPS-1:0] timed_out,
   output logic [STEP_W-1:0]    current_step,
   output logic                 done
);

   logic [2:0]           state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [NUM_STEPS-1:0] initiate_q, initiate_d;
   logic [NUM_STEPS-1:0] has_occurred_q, has_occurred_d;
   logic [NUM_STEPS-1:0] timed_out_q, timed_out_d;
   logic                 done_q, done_d;

   logic [NUM_STEPS-1:0] step_oh;
   logic cur_enable;
   logic cur_manual;
   logic cur_busy;
   logic last_step;
   logic delay_clear, delay_en, delay_expired;
   logic tmo_clear, tmo_en, tmo_expired;

   assign step_oh    = NUM_STEPS'(1) << step_q;
   assign cur_enable = |(step_enable & step_oh);
   assign cur_manual = |(manual_mask & step_oh);
   assign cur_busy   = |(step_busy & step_oh);
   assign last_step  = (step_q == STEP_W'(NUM_STEPS - 1));

   // Delay is held at zero outside WAIT so every WAIT entry starts fresh,
   // including the re-armed last step in repeat mode.
   assign delay_clear = reset | restart | (state_q != ST_WAIT);
   assign tmo_clear   = reset | restart | (state_q == ST_FIRE);

   pickoff_counter #(
      .PICKOFF (DELAY_PICKOFF)
   ) u_delay (
      .clock   (clock100),
      .clear   (delay_clear),
      .enable  (delay_en),
      .expired (delay_expired)
   );

   pickoff_counter #(
      .PICKOFF (TIMEOUT_PICKOFF)
   ) u_timeout (
      .clock   (clock100),
      .clear   (tmo_clear),
      .enable  (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      timed_out_d = timed_out_q;
      delay_en    = 1'b0;
      tmo_en      = 1'b0;

      case (state_q)
         ST_WAIT: begin
            if (!cur_enable) begin
               state_d = ST_NEXT;
            end else if (cur_manual) begin
               if (trigger_pulse) begin
                  state_d = ST_FIRE;
               end
            end else if (delay_expired) begin
               state_d = ST_FIRE;
            end else begin
               delay_en = 1'b1;
            end
         end
         ST_FIRE: begin
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (!cur_busy) begin
               state_d = ST_NEXT;
            end else if (tmo_expired) begin
               timed_out_d = timed_out_q | step_oh;
               state_d     = ST_NEXT;
            end else begin
               tmo_en = 1'b1;
            end
         end
         ST_NEXT: begin
            if (last_step) begin
               state_d = ST_DONE;
            end else begin
               step_d  = step_q + STEP_W'(1);
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (repeat_mode) begin
               step_d  = STEP_W'(NUM_STEPS - 1);
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase

      // Outputs are registered from the next state so the pulse and the
      // sticky flag line up with the FIRE cycle itself.
      initiate_d     = (state_d == ST_FIRE) ? step_oh : '0;
      has_occurred_d = has_occurred_q | initiate_d;
      done_d         = (state_d == ST_DONE);
   end

   // Restart behaves exactly like reset and overrides everything else.
   always_ff @(posedge clock100) begin
      if (reset || restart) begin
         state_q        <= ST_WAIT;
         step_q         <= '0;
         initiate_q     <= '0;
         has_occurred_q <= '0;
         timed_out_q    <= '0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         initiate_q     <= initiate_d;
         has_occurred_q <= has_occurred_d;
         timed_out_q    <= timed_out_d;
         done_q         <= done_d;
      end
   end

   assign initiate     = initiate_q;
   assign has_occurred = has_occurred_q;
   assign timed_out    = timed_out_q;
   assign current_step = step_q;
   assign done         = done_q;

endmodule

// File: tb/tb_alpha_bringup_sequencer.sv
// Self-checking bench for alpha_bringup_sequencer: a timeline model derived
// from the step rules predicts every initiate, timeout and done cycle.
module tb_alpha_bringup_sequencer;

   localparam int N        = 4;
   localparam int DP       = 4;
   localparam int TP       = 3;
   localparam int AUTO_LAT = (1 << DP) + 1;
   localparam int TMO_LIM  = 1 << TP;

   logic         clock100 = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] step_enable = '0;
   logic [N-1:0] manual_mask = '0;
   logic         trigger_pulse = 1'b0;
   logic         restart = 1'b0;
   logic         repeat_mode = 1'b0;
   logic [N-1:0] step_busy = '0;
   logic [N-1:0] initiate;
   logic [N-1:0] has_occurred;
   logic [N-1:0] timed_out;
   logic [1:0]   current_step;
   logic         done;

   int checks = 0;
   int errors = 0;

   alpha_bringup_sequencer #(
      .NUM_STEPS       (N),
      .DELAY_PICKOFF   (DP),
      .TIMEOUT_PICKOFF (TP)
   ) dut (
      .clock100      (clock100),
      .reset         (reset),
      .step_enable   (step_enable),
      .manual_mask   (manual_mask),
      .trigger_pulse (trigger_pulse),
      .restart       (restart),
      .repeat_mode   (repeat_mode),
      .step_busy     (step_busy),
      .initiate      (initiate),
      .has_occurred  (has_occurred),
      .timed_out     (timed_out),
      .current_step  (current_step),
      .done          (done)
   );

   always #5 clock100 = ~clock100;

   // mode 0: start by reset, 1: start by restart, 2: already at cycle 0.
   // Cycle 0 is the first cycle the sequencer spends in WAIT of step 0.
   task automatic run_sequence(input string name, input int mode,
                               input logic [N-1:0] en,
                               input logic [N-1:0] mask,
                               input int b0, input int b1,
                               input int b2, input int b3,
                               input int nrep);
      int bd[N];
      int exp_fire[N][4];
      int exp_n[N];
      int obs_fire[N][4];
      int obs_n[N];
      int exp_to[N];
      int obs_to[N];
      int last_fire[N];
      int exp_done[4];
      int obs_done[4];
      int n_exp_done;
      int n_obs_done;
      int trig_q[$];
      int w, t, f, k, end_c, onehot_bad, ov;
      logic prev_done, done_end;
      logic [N-1:0] exp_to_vec, snap_ho, snap_to;
      logic [1:0] snap_step;

      bd[0] = b0; bd[1] = b1; bd[2] = b2; bd[3] = b3;
      exp_to_vec = '0;
      snap_ho = 'x; snap_to = 'x; snap_step = 'x;
      done_end = 1'bx;
      for (int i = 0; i < N; i++) begin
         exp_n[i] = 0; obs_n[i] = 0;
         exp_to[i] = -1; obs_to[i] = -1;
         last_fire[i] = -100000;
      end

      // Timeline model: disabled step costs 2 cycles; an enabled step
      // fires after the delay or one cycle after its trigger, then spends
      // min(busy, 2^TP) cycles busy plus FIRE/BUSY/NEXT overhead.
      w = 0;
      for (int i = 0; i < N; i++) begin
         if (!en[i]) begin
            w += 2;
         end else begin
            if (mask[i]) begin
               t = w + $urandom_range(0, 5);
               trig_q.push_back(t);
               f = t + 1;
            end else begin
               f = w + AUTO_LAT;
            end
            exp_fire[i][exp_n[i]] = f;
            exp_n[i]++;
            // a pulse during BUSY must be ignored
            if ($urandom_range(0, 1) == 1) trig_q.push_back(f + 1);
            k = (bd[i] > TMO_LIM) ? TMO_LIM : bd[i];
            if (bd[i] > TMO_LIM) begin
               exp_to_vec[i] = 1'b1;
               exp_to[i] = f + TMO_LIM + 2;
            end
            w = f + 3 + k;
         end
      end
      exp_done[0] = w;
      n_exp_done = 1;
      for (int r = 0; r < nrep; r++) begin
         t = w + 1 + $urandom_range(0, 5);
         trig_q.push_back(t);
         f = t + 1;
         exp_fire[N-1][exp_n[N-1]] = f;
         exp_n[N-1]++;
         k = (bd[N-1] > TMO_LIM) ? TMO_LIM : bd[N-1];
         w = f + 3 + k;
         exp_done[n_exp_done] = w;
         n_exp_done++;
      end
      end_c = w + 3;

      step_enable   = en;
      manual_mask   = mask;
      repeat_mode   = (nrep > 0);
      trigger_pulse = 1'b0;
      step_busy     = '0;
      if (mode == 0) begin
         reset = 1'b1;
         @(negedge clock100);
         reset = 1'b0;
      end else if (mode == 1) begin
         restart = 1'b1;
         @(negedge clock100);
         restart = 1'b0;
      end

      prev_done = 1'b0;
      onehot_bad = 0;
      n_obs_done = 0;
      for (int c = 0; c <= end_c; c++) begin
         if ($countones(initiate) > 1) onehot_bad++;
         for (int i = 0; i < N; i++) begin
            if (initiate[i]) begin
               if (obs_n[i] < 4) obs_fire[i][obs_n[i]] = c;
               obs_n[i]++;
               last_fire[i] = c;
            end
            if (timed_out[i] && obs_to[i] < 0) obs_to[i] = c;
         end
         if (done && !prev_done) begin
            if (n_obs_done < 4) obs_done[n_obs_done] = c;
            n_obs_done++;
         end
         prev_done = done;
         if (c == exp_done[n_exp_done-1]) begin
            snap_ho = has_occurred;
            snap_to = timed_out;
            snap_step = current_step;
         end
         if (c == end_c) done_end = done;
         trigger_pulse = 1'b0;
         foreach (trig_q[j]) if (trig_q[j] == c) trigger_pulse = 1'b1;
         for (int i = 0; i < N; i++) begin
            step_busy[i] = (c > last_fire[i]) && (c <= last_fire[i] + bd[i]);
         end
         @(negedge clock100);
      end
      trigger_pulse = 1'b0;
      step_busy = '0;

      for (int i = 0; i < N; i++) begin
         checks++;
         if (obs_n[i] !== exp_n[i]) begin
            errors++;
            $display("FAIL %s fire_count[%0d]: got %0d want %0d",
                     name, i, obs_n[i], exp_n[i]);
         end
         for (int j = 0; j < exp_n[i]; j++) begin
            ov = (j < obs_n[i]) ? obs_fire[i][j] : -1;
            checks++;
            if (ov !== exp_fire[i][j]) begin
               errors++;
               $display("FAIL %s fire_cycle[%0d][%0d]: got %0d want %0d",
                        name, i, j, ov, exp_fire[i][j]);
            end
         end
         checks++;
         if (obs_to[i] !== exp_to[i]) begin
            errors++;
            $display("FAIL %s timeout_cycle[%0d]: got %0d want %0d",
                     name, i, obs_to[i], exp_to[i]);
         end
      end
      checks++;
      if (n_obs_done !== n_exp_done) begin
         errors++;
         $display("FAIL %s done_count: got %0d want %0d",
                  name, n_obs_done, n_exp_done);
      end
      for (int j = 0; j < n_exp_done; j++) begin
         ov = (j < n_obs_done) ? obs_done[j] : -1;
         checks++;
         if (ov !== exp_done[j]) begin
            errors++;
            $display("FAIL %s done_cycle[%0d]: got %0d want %0d",
                     name, j, ov, exp_done[j]);
         end
      end
      checks++;
      if (snap_ho !== en) begin
         errors++;
         $display("FAIL %s has_occurred: got %b want %b", name, snap_ho, en);
      end
      checks++;
      if (snap_to !== exp_to_vec) begin
         errors++;
         $display("FAIL %s timed_out: got %b want %b",
                  name, snap_to, exp_to_vec);
      end
      checks++;
      if (snap_step !== 2'(N - 1)) begin
         errors++;
         $display("FAIL %s current_step: got %0d want %0d",
                  name, snap_step, N - 1);
      end
      checks++;
      if (onehot_bad !== 0) begin
         errors++;
         $display("FAIL %s onehot: got %0d bad cycles want 0",
                  name, onehot_bad);
      end
      checks++;
      if (done_end !== (nrep == 0)) begin
         errors++;
         $display("FAIL %s done_hold: got %b want %b",
                  name, done_end, (nrep == 0));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step_enable = 4'($urandom);
      manual_mask = '0;
      trigger_pulse = 1'b1;
      step_busy = 4'($urandom);
      @(negedge clock100);
      @(negedge clock100);
      @(negedge clock100);
      checks++;
      if (initiate !== '0) begin
         errors++;
         $display("FAIL reset initiate: got %b want 0000", initiate);
      end
      checks++;
      if (has_occurred !== '0) begin
         errors++;
         $display("FAIL reset has_occurred: got %b want 0000", has_occurred);
      end
      checks++;
      if (timed_out !== '0) begin
         errors++;
         $display("FAIL reset timed_out: got %b want 0000", timed_out);
      end
      checks++;
      if (current_step !== 2'd0) begin
         errors++;
         $display("FAIL reset current_step: got %0d want 0", current_step);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset done: got %b want 0", done);
      end
      trigger_pulse = 1'b0;
      step_busy = '0;
   endtask

   task automatic test_auto_steps();
      run_sequence("auto", 0, 4'b1111, 4'b1000, 0, 0, 0, 0, 0);
   endtask

   task automatic test_skip();
      run_sequence("skip", 1, 4'b0101, 4'b0000, 0, 0, 0, 0, 0);
   endtask

   task automatic test_all_disabled();
      run_sequence("all_off", 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
   endtask

   task automatic test_timeout();
      run_sequence("timeout", 0, 4'b1111, 4'b0000, 0, 1000, 0, 0, 0);
   endtask

   task automatic test_busy_handshake();
      run_sequence("busy", 1, 4'b1111, 4'b0000, 5, 8, 0, 0, 0);
   endtask

   task automatic test_repeat();
      run_sequence("repeat", 0, 4'b1111, 4'b1000, 0, 0, 0, 0, 2);
   endtask

   task automatic test_restart();
      bit seen;
      step_enable = 4'b1111;
      manual_mask = '0;
      repeat_mode = 1'b0;
      trigger_pulse = 1'b0;
      step_busy = 4'b0110;
      reset = 1'b1;
      @(negedge clock100);
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clock100);
         if (initiate[2]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL restart reach_step2: got 0 want 1");
      end
      @(negedge clock100);
      checks++;
      if ({has_occurred, timed_out} !== {4'b0111, 4'b0010}) begin
         errors++;
         $display("FAIL restart pre_flags: got %b/%b want 0111/0010",
                  has_occurred, timed_out);
      end
      restart = 1'b1;
      trigger_pulse = 1'b1;
      @(negedge clock100);
      restart = 1'b0;
      trigger_pulse = 1'b0;
      step_busy = '0;
      checks++;
      if ({initiate, has_occurred, timed_out} !== 12'd0) begin
         errors++;
         $display("FAIL restart flags: got %b/%b/%b want all 0",
                  initiate, has_occurred, timed_out);
      end
      checks++;
      if ({current_step, done} !== 3'd0) begin
         errors++;
         $display("FAIL restart step_done: got %0d/%b want 0/0",
                  current_step, done);
      end
      run_sequence("restart_rerun", 2, 4'b1111, 4'b0001, 0, 3, 0, 0, 0);
   endtask

   task automatic test_random();
      logic [N-1:0] en, mask;
      int nrep;
      for (int it = 0; it < 10; it++) begin
         en = 4'($urandom);
         mask = 4'($urandom);
         nrep = (en[N-1] && mask[N-1]) ? $urandom_range(0, 2) : 0;
         run_sequence("random", $urandom_range(0, 1), en, mask,
                      $urandom_range(0, 12), $urandom_range(0, 12),
                      $urandom_range(0, 12), $urandom_range(0, 12), nrep);
      end
   endtask

   initial begin
      test_reset();
      test_auto_steps();
      test_skip();
      test_all_disabled();
      test_timeout();
      test_busy_handshake();
      test_repeat();
      test_restart();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
